uart_tx_queue: RTL and testbench

- Byte queue that sits directly upstream of the UART transmitter.
- Accepts bytes from the bus/register side and stores them in a FIFO.
- Issues them one at a time on the transmitter's request/busy handshake: oTX_REQ/oTX_DATA drive the transmitter's TX_REQ/TX_DATA, and iTX_BUSY is the transmitter's TX_BUSY.
- Lets software queue several bytes without polling busy per byte.

---
 rtl/uart_tx_queue.sv | 128 ++++++++++++
 tb/tb_uart_tx_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO that feeds a UART transmitter over its req/busy handshake.
// Optional threshold interrupt (oIRQ, iIRQ_THRESH, iIRQ_ACK) when UART_TX_QUEUE_IRQ_EN is defined.
module uart_tx_queue #(
  parameter int DEPTH_N = 4
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iWR_REQ,
  input  logic [7:0]       iWR_DATA,
  output logic             oWR_FULL,
  output logic             oEMPTY,
  output logic [DEPTH_N:0] oCOUNT,
  output logic             oOVERFLOW,
  input  logic             iFLUSH,
  output logic             oTX_REQ,
  output logic [7:0]       oTX_DATA,
  input  logic             iTX_BUSY,
`ifdef UART_TX_QUEUE_IRQ_EN
  input  logic [DEPTH_N:0] iIRQ_THRESH,
  input  logic             iIRQ_ACK,
  output logic             oIRQ,
`endif
  output logic             oIDLE
);

  localparam int DEPTH = 1 << DEPTH_N;
  localparam logic [DEPTH_N:0]   COUNT_FULL = (DEPTH_N + 1)'(DEPTH);
  localparam logic [DEPTH_N:0]   COUNT_ONE  = (DEPTH_N + 1)'(1);
  localparam logic [DEPTH_N-1:0] PTR_ONE    = DEPTH_N'(1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state, state_next;
  logic [7:0]         mem [DEPTH];
  logic [DEPTH_N-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_N:0]   count, count_next;
  logic               full, pop, push, drop;
  logic               overflow, tx_req;
  logic [7:0]         tx_data;

  assign full = (count == COUNT_FULL);

  always_comb begin
    // NOTE: defaults first so every path assigns every variable (no inferred latch).
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        // Flush wins over an issue in the same cycle.
        if (!iFLUSH && count != '0 && !iTX_BUSY) begin
          pop        = 1'b1;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (iTX_BUSY) state_next = WAIT_DONE;
      WAIT_DONE: if (!iTX_BUSY) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // A pop on the same edge frees a slot, so a write into a full queue is accepted.
  assign push = iWR_REQ && !iFLUSH && (!full || pop);
  assign drop = iWR_REQ && !iFLUSH && full && !pop;

  always_comb begin
    count_next = count;
    if (iFLUSH)              count_next = '0;
    else if (push && !pop)   count_next = count + COUNT_ONE;
    else if (pop && !push)   count_next = count - COUNT_ONE;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_req   <= 1'b0;
      tx_data  <= '0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      state  <= state_next;
      count  <= count_next;
      tx_req <= pop;
      if (pop) tx_data <= mem[rd_ptr];
      if (iFLUSH) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (drop) overflow <= 1'b1;
      end
    end
  end

  // NOTE: the storage array is not reset; pointers and count define which entries are valid.
  always_ff @(posedge iCLOCK) begin
    if (push) mem[wr_ptr] <= iWR_DATA;
  end

  assign oWR_FULL  = full;
  assign oEMPTY    = (count == '0);
  assign oCOUNT    = count;
  assign oOVERFLOW = overflow;
  assign oTX_REQ   = tx_req;
  assign oTX_DATA  = tx_data;
  assign oIDLE     = (count == '0) && (state == IDLE) && !iTX_BUSY;

`ifdef UART_TX_QUEUE_IRQ_EN
  logic irq;

  // Fires on the downward crossing of the threshold; a flush never raises it.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)
      irq <= 1'b0;
    else if (!iFLUSH && count > iIRQ_THRESH && count_next <= iIRQ_THRESH)
      irq <= 1'b1;
    else if (iIRQ_ACK)
      irq <= 1'b0;
  end

  assign oIRQ = irq;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed table plus hand-written sequences for uart_tx_queue (DEPTH_N=2).
// A small transmitter model raises busy after each request for busy_len cycles.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req, flush;
  logic [7:0] wr_data;
  logic       wr_full, empty, overflow, tx_req, idle;
  logic [2:0] count;
  logic [7:0] tx_data;
  logic       tx_busy, force_busy, model_busy;
  int         model_cnt, busy_len;
  logic       prev_req;
  logic [7:0] req_q [$];
  int         n_cmp = 0, n_err = 0;
`ifdef UART_TX_QUEUE_IRQ_EN
  logic [2:0] irq_thresh;
  logic       irq_ack, irq;
`endif

  always #5 clk = ~clk;

  assign tx_busy = force_busy | model_busy;

  uart_tx_queue #(.DEPTH_N(2)) dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iWR_REQ(wr_req), .iWR_DATA(wr_data),
    .oWR_FULL(wr_full), .oEMPTY(empty), .oCOUNT(count), .oOVERFLOW(overflow),
    .iFLUSH(flush),
    .oTX_REQ(tx_req), .oTX_DATA(tx_data), .iTX_BUSY(tx_busy),
`ifdef UART_TX_QUEUE_IRQ_EN
    .iIRQ_THRESH(irq_thresh), .iIRQ_ACK(irq_ack), .oIRQ(irq),
`endif
    .oIDLE(idle)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transmitter model: busy rises in the cycle after the request, falls busy_len cycles later.
  initial begin
    model_busy = 1'b0;
    model_cnt  = 0;
    prev_req   = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_req) begin
        check("req_single_cycle", {31'b0, prev_req}, 32'd0);
        req_q.push_back(tx_data);
        model_cnt  = busy_len;
        model_busy = 1'b1;
      end else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) model_busy = 1'b0;
      end
      prev_req = tx_req;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(logic [7:0] d);
    wr_req  = 1'b1;
    wr_data = d;
    tick();
    wr_req  = 1'b0;
  endtask

  task automatic wait_idle(string name, int n_req, int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (idle && req_q.size() == n_req) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       flush;
    logic       busy;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       idle;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Fill to depth 4 with the transmitter busy, overflow once, then flush.
    vecs[0] = '{1'b1, 8'hA0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hA1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'hA2, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'hA3, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'hA4, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'hB0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; wr_req = 1'b0; wr_data = '0; flush = 1'b0;
    force_busy = 1'b0; busy_len = 4;
`ifdef UART_TX_QUEUE_IRQ_EN
    irq_thresh = 3'd4; irq_ack = 1'b0;
`endif
    tick(2);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, wr_full}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    check("rst_req", {31'b0, tx_req}, 32'd0);
    check("rst_data", {24'b0, tx_data}, 32'h00);
    check("rst_idle", {31'b0, idle}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Single byte latency: count=1 after the write edge, request one edge later.
    write(8'h55);
    check("t1_count1", {29'b0, count}, 32'd1);
    check("t1_noreq", {31'b0, tx_req}, 32'd0);
    tick();
    check("t1_req", {31'b0, tx_req}, 32'd1);
    check("t1_data", {24'b0, tx_data}, 32'h55);
    check("t1_count0", {29'b0, count}, 32'd0);
    tick();
    check("t1_req_low", {31'b0, tx_req}, 32'd0);
    tick(2);
    check("t1_data_hold", {24'b0, tx_data}, 32'h55);
    wait_idle("t1_idle", 1, 100);

    // Three bytes with a slow transmitter.
    busy_len = 40;
    req_q.delete();
    write(8'h01); write(8'h02); write(8'h03);
    wait_idle("t2_idle", 3, 400);
    check("t2_nreq", req_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < req_q.size(); i++)
      check($sformatf("t2_order%0d", i), {24'b0, req_q[i]}, i + 1);
    check("t2_idle_out", {31'b0, idle}, 32'd1);

    // Table: fill, overflow, flush, write ignored under flush.
    for (int i = 0; i < 9; i++) begin
      wr_req = vecs[i].wr; wr_data = vecs[i].data;
      flush = vecs[i].flush; force_busy = vecs[i].busy;
      tick();
      check($sformatf("v%0d_count", i), {29'b0, count}, {29'b0, vecs[i].count});
      check($sformatf("v%0d_full", i), {31'b0, wr_full}, {31'b0, vecs[i].full});
      check($sformatf("v%0d_empty", i), {31'b0, empty}, {31'b0, vecs[i].empty});
      check($sformatf("v%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].ovf});
      check($sformatf("v%0d_idle", i), {31'b0, idle}, {31'b0, vecs[i].idle});
    end
    wr_req = 1'b0; flush = 1'b0;

    // Full queue: pop and write on the same edge, then drain across pointer wrap.
    force_busy = 1'b1;
    busy_len = 6;
    write(8'hC0); write(8'hC1); write(8'hC2); write(8'hC3);
    check("t4_full", {31'b0, wr_full}, 32'd1);
    req_q.delete();
    force_busy = 1'b0;
    write(8'hC4);
    check("t4_count", {29'b0, count}, 32'd4);
    check("t4_ovf", {31'b0, overflow}, 32'd0);
    check("t4_req", {31'b0, tx_req}, 32'd1);
    check("t4_data", {24'b0, tx_data}, 32'hC0);
    wait_idle("t4_idle", 5, 300);
    for (int i = 0; i < 5 && i < req_q.size(); i++)
      check($sformatf("t4_order%0d", i), {24'b0, req_q[i]}, 32'hC0 + i);

    // Flush while a byte is in flight: it completes, nothing else issues.
    busy_len = 20;
    req_q.delete();
    write(8'hD0); write(8'hD1); write(8'hD2); write(8'hD3);
    check("t5_count3", {29'b0, count}, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flushed", {29'b0, count}, 32'd0);
    check("t5_busy_kept", {31'b0, tx_busy}, 32'd1);
    wait_idle("t5_idle", 1, 100);
    tick(10);
    check("t5_nreq", req_q.size(), 32'd1);
    if (req_q.size() > 0) check("t5_data", {24'b0, req_q[0]}, 32'hD0);

    // Busy held in IDLE: no issue until it drops.
    busy_len = 4;
    req_q.delete();
    force_busy = 1'b1;
    write(8'hF0);
    tick(5);
    check("t6_held_count", {29'b0, count}, 32'd1);
    check("t6_held_nreq", req_q.size(), 32'd0);
    force_busy = 1'b0;
    tick();
    check("t6_req", {31'b0, tx_req}, 32'd1);
    check("t6_data", {24'b0, tx_data}, 32'hF0);
    wait_idle("t6_idle", 1, 100);

    // Asynchronous reset in WAIT_DONE.
    busy_len = 30;
    write(8'hE0); write(8'hE1); write(8'hE2);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("t7_req", {31'b0, tx_req}, 32'd0);
    check("t7_data", {24'b0, tx_data}, 32'h00);
    check("t7_count", {29'b0, count}, 32'd0);
    check("t7_empty", {31'b0, empty}, 32'd1);
    check("t7_full", {31'b0, wr_full}, 32'd0);
    check("t7_ovf", {31'b0, overflow}, 32'd0);
    check("t7_idle", {31'b0, idle}, {31'b0, ~tx_busy});
    tick();
    rst_n = 1'b1;
    req_q.delete();
    wait_idle("t7_idle_after", 0, 100);

`ifdef UART_TX_QUEUE_IRQ_EN
    // Threshold interrupt while draining three bytes.
    begin
      bit hit = 1'b0;
      irq_thresh = 3'd1;
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      check("t8_irq_clear", {31'b0, irq}, 32'd0);
      force_busy = 1'b1;
      busy_len = 4;
      write(8'h71); write(8'h72); write(8'h73);
      check("t8_irq_low3", {31'b0, irq}, 32'd0);
      force_busy = 1'b0;
      for (int i = 0; i < 200; i++) begin
        tick();
        if (count == 3'd2) check("t8_irq_low2", {31'b0, irq}, 32'd0);
        if (count == 3'd1) begin
          hit = 1'b1;
          break;
        end
      end
      check("t8_reach1", {31'b0, hit}, 32'd1);
      check("t8_irq_set", {31'b0, irq}, 32'd1);
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      check("t8_irq_ack", {31'b0, irq}, 32'd0);
      wait_idle("t8_idle", 3, 200);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
